// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retirement of out-of-order completions,
// with CDB completion marking and branch-mispredict flush of younger entries.
module reorder_buffer #(
    parameter int ROB_WIDTH  = 4,
    parameter int AREG_WIDTH = 5,
    parameter int PREG_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dispatch_valid,
    input  logic [ROB_WIDTH-1:0]  dispatch_tag,
    input  logic                  dispatch_has_dest,
    input  logic [AREG_WIDTH-1:0] dispatch_areg,
    input  logic [PREG_WIDTH-1:0] dispatch_preg,
    input  logic [PREG_WIDTH-1:0] dispatch_old_preg,
    output logic                  rob_full,
    output logic                  rob_empty,
    output logic [ROB_WIDTH:0]    rob_count,
    input  logic                  cdb_valid,
    input  logic [ROB_WIDTH-1:0]  cdb_tag,
    input  logic                  branch_mispredict,
    input  logic [ROB_WIDTH-1:0]  recovery_tag,
    output logic                  commit_valid,
    output logic [ROB_WIDTH-1:0]  commit_tag,
    output logic                  commit_has_dest,
    output logic [AREG_WIDTH-1:0] commit_areg,
    output logic [PREG_WIDTH-1:0] commit_preg,
    output logic [PREG_WIDTH-1:0] commit_old_preg
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH+1)'(DEPTH);

    logic [ROB_WIDTH-1:0]  head;
    logic [ROB_WIDTH-1:0]  tail;
    logic [ROB_WIDTH-1:0]  rec_off;
    logic [ROB_WIDTH:0]    count;
    logic [ROB_WIDTH:0]    count_next;
    logic [DEPTH-1:0]      valid;
    logic [DEPTH-1:0]      done;
    logic [DEPTH-1:0]      has_dest;
    logic [DEPTH-1:0]      younger;
    logic [AREG_WIDTH-1:0] areg     [DEPTH];
    logic [PREG_WIDTH-1:0] preg     [DEPTH];
    logic [PREG_WIDTH-1:0] old_preg [DEPTH];
    logic                  dispatch_ok;
    logic                  flush_ok;

    assign tail        = head + count[ROB_WIDTH-1:0];
    assign rob_full    = (count == FULL_CNT);
    assign rob_empty   = (count == '0);
    assign rob_count   = count;
    assign dispatch_ok = dispatch_valid && !rob_full && !branch_mispredict;
    assign flush_ok    = branch_mispredict && valid[recovery_tag];
    assign rec_off     = recovery_tag - head;

    assign commit_valid    = valid[head] && done[head];
    assign commit_tag      = commit_valid ? head : '0;
    assign commit_has_dest = commit_valid && has_dest[head];
    assign commit_areg     = commit_valid ? areg[head] : '0;
    assign commit_preg     = commit_valid ? preg[head] : '0;
    assign commit_old_preg = commit_valid ? old_preg[head] : '0;

    // Age is the distance from head; anything further than the branch is younger.
    always_comb begin
        younger = '0;
        for (int i = 0; i < DEPTH; i++)
            younger[i] = (ROB_WIDTH'(i) - head) > rec_off;
    end

    always_comb begin
        if (flush_ok)
            count_next = (ROB_WIDTH+1)'(rec_off) + (ROB_WIDTH+1)'(1)
                       - (ROB_WIDTH+1)'(commit_valid);
        else
            count_next = count + (ROB_WIDTH+1)'(dispatch_ok)
                       - (ROB_WIDTH+1)'(commit_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            head  <= head + ROB_WIDTH'(commit_valid);
            count <= count_next;
            // Later assignments take priority: flush kills CDB, dispatch beats CDB.
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_valid && cdb_tag == ROB_WIDTH'(i) && valid[i])
                    done[i] <= 1'b1;
                if (commit_valid && head == ROB_WIDTH'(i)) begin
                    valid[i] <= 1'b0;
                    done[i]  <= 1'b0;
                end
                if (flush_ok && younger[i]) begin
                    valid[i] <= 1'b0;
                    done[i]  <= 1'b0;
                end
                if (dispatch_ok && dispatch_tag == ROB_WIDTH'(i)) begin
                    valid[i] <= 1'b1;
                    done[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dispatch_ok) begin
            has_dest[dispatch_tag] <= dispatch_has_dest;
            areg[dispatch_tag]     <= dispatch_areg;
            preg[dispatch_tag]     <= dispatch_preg;
            old_preg[dispatch_tag] <= dispatch_old_preg;
        end
    end

    a_dispatch_tag: assert property (@(posedge clk) disable iff (reset)
        dispatch_ok |-> dispatch_tag == tail);

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-of-instructions model predicts
// commits and occupancy; a negedge monitor compares the commit port.
module tb_reorder_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic       dispatch_valid, dispatch_has_dest;
    logic [3:0] dispatch_tag;
    logic [4:0] dispatch_areg;
    logic [6:0] dispatch_preg, dispatch_old_preg;
    logic       rob_full, rob_empty;
    logic [4:0] rob_count;
    logic       cdb_valid, branch_mispredict;
    logic [3:0] cdb_tag, recovery_tag;
    logic       commit_valid, commit_has_dest;
    logic [3:0] commit_tag;
    logic [4:0] commit_areg;
    logic [6:0] commit_preg, commit_old_preg;

    reorder_buffer #(.ROB_WIDTH(4), .AREG_WIDTH(5), .PREG_WIDTH(7)) dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_tag(dispatch_tag),
        .dispatch_has_dest(dispatch_has_dest), .dispatch_areg(dispatch_areg),
        .dispatch_preg(dispatch_preg), .dispatch_old_preg(dispatch_old_preg),
        .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .branch_mispredict(branch_mispredict), .recovery_tag(recovery_tag),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_has_dest(commit_has_dest), .commit_areg(commit_areg),
        .commit_preg(commit_preg), .commit_old_preg(commit_old_preg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tag;
        logic       done;
        logic       hd;
        logic [4:0] ar;
        logic [6:0] pr;
        logic [6:0] op;
    } ent_t;

    ent_t       m_q[$];     // in-flight instructions, oldest first
    ent_t       exp_q[$];   // expected commits
    logic [3:0] m_head;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 0;
    logic       nxt_hd;
    logic [4:0] nxt_ar;
    logic [6:0] nxt_pr, nxt_op;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_payload();
        nxt_hd = 1'($urandom);
        nxt_ar = 5'($urandom);
        nxt_pr = 7'($urandom);
        nxt_op = 7'($urandom);
    endtask

    // Occupancy check, and schedule the commit the model expects this cycle.
    task automatic check_state();
        int n = m_q.size();
        chk("rob_state", {rob_full, rob_empty, rob_count},
            {(n == 16), (n == 0), 5'(n)});
        if (n > 0 && m_q[0].done) exp_q.push_back(m_q[0]);
    endtask

    task automatic step(input bit dv, input bit cv, input logic [3:0] ct,
                        input bit bm, input logic [3:0] rt);
        bit   com, full;
        int   k;
        ent_t e;
        dispatch_valid    = dv;
        dispatch_tag      = m_head + 4'(m_q.size());
        dispatch_has_dest = nxt_hd;
        dispatch_areg     = nxt_ar;
        dispatch_preg     = nxt_pr;
        dispatch_old_preg = nxt_op;
        cdb_valid         = cv;
        cdb_tag           = ct;
        branch_mispredict = bm;
        recovery_tag      = rt;
        com  = m_q.size() > 0 && m_q[0].done;
        full = m_q.size() == 16;
        k    = -1;
        foreach (m_q[i]) if (m_q[i].tag == rt) k = i;
        if (cv) foreach (m_q[i]) if (m_q[i].tag == ct) m_q[i].done = 1'b1;
        if (bm && k >= 0) while (m_q.size() > k + 1) void'(m_q.pop_back());
        if (com) begin
            void'(m_q.pop_front());
            m_head++;
        end
        if (dv && !full && !bm) begin
            e.tag = dispatch_tag; e.done = 1'b0; e.hd = nxt_hd;
            e.ar = nxt_ar; e.pr = nxt_pr; e.op = nxt_op;
            m_q.push_back(e);
        end
        rand_payload();
        @(posedge clk); #1;
        check_state();
    endtask

    task automatic idle();
        step(0, 0, 4'd0, 0, 4'd0);
    endtask

    task automatic dsp();
        step(1, 0, 4'd0, 0, 4'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        dispatch_valid = 0; cdb_valid = 0; branch_mispredict = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_q.delete();
        exp_q.delete();
        m_head = 4'd0;
        mon_en = 1;
        chk("reset_state", {rob_full, rob_empty, rob_count, commit_valid}, {1'b0, 1'b1, 5'd0, 1'b0});
        chk("reset_commit_fields", {commit_tag, commit_has_dest, commit_areg, commit_preg, commit_old_preg}, 0);
    endtask

    // Complete the oldest unfinished entry each cycle until the model is empty.
    task automatic drain();
        for (int n = 0; n < 80 && m_q.size() > 0; n++) begin
            int f = -1;
            foreach (m_q[i]) if (f < 0 && !m_q[i].done) f = i;
            if (f >= 0) step(0, 1, m_q[f].tag, 0, 4'd0);
            else idle();
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            ent_t e;
            checks++;
            if (commit_valid !== (exp_q.size() > 0)) begin
                errors++;
                $display("FAIL commit_valid: got %0b expected %0b at %0t",
                         commit_valid, exp_q.size() > 0, $time);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (commit_valid) begin
                    checks++;
                    if ({commit_tag, commit_has_dest, commit_areg, commit_preg, commit_old_preg}
                        !== {e.tag, e.hd, e.ar, e.pr, e.op}) begin
                        errors++;
                        $display("FAIL commit_fields: got tag=%0d hd=%0b areg=%0d preg=%0d old=%0d expected tag=%0d hd=%0b areg=%0d preg=%0d old=%0d",
                                 commit_tag, commit_has_dest, commit_areg, commit_preg, commit_old_preg,
                                 e.tag, e.hd, e.ar, e.pr, e.op);
                    end
                end
            end else if (!commit_valid) begin
                checks++;
                if ({commit_tag, commit_has_dest, commit_areg, commit_preg, commit_old_preg} !== '0) begin
                    errors++;
                    $display("FAIL commit_idle_fields: got nonzero tag=%0d preg=%0d expected 0",
                             commit_tag, commit_preg);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        dispatch_valid = 0; dispatch_tag = 0; dispatch_has_dest = 0;
        dispatch_areg = 0; dispatch_preg = 0; dispatch_old_preg = 0;
        cdb_valid = 0; cdb_tag = 0; branch_mispredict = 0; recovery_tag = 0;
        m_head = 4'd0;
        rand_payload();
        repeat (2) @(posedge clk);

        // Fill to 16, then a dropped 17th dispatch.
        do_reset();
        repeat (16) dsp();
        chk("full_after_16", {rob_full, rob_count}, {1'b1, 5'd16});
        dsp();
        chk("17th_dropped", {rob_full, rob_count}, {1'b1, 5'd16});
        drain();

        // Out-of-order completion, in-order retirement.
        do_reset();
        repeat (3) dsp();
        step(0, 1, 4'd2, 0, 4'd0);
        step(0, 1, 4'd0, 0, 4'd0);
        repeat (3) idle();
        chk("tag2_waits_for_tag1", rob_count, 2);
        step(0, 1, 4'd1, 0, 4'd0);
        repeat (3) idle();

        // Payload routed to the commit port.
        do_reset();
        nxt_hd = 1; nxt_ar = 5'd5; nxt_pr = 7'd40; nxt_op = 7'd5;
        dsp();
        step(0, 1, 4'd0, 0, 4'd0);
        chk("commit_payload", {commit_valid, commit_tag, commit_has_dest, commit_areg, commit_preg, commit_old_preg},
            {1'b1, 4'd0, 1'b1, 5'd5, 7'd40, 7'd5});
        idle();

        // Wrap-around flush: head=14, keep 14..15.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            dsp();
            step(0, 1, m_head, 0, 4'd0);
            idle();
        end
        repeat (5) dsp();
        step(0, 0, 4'd0, 1, 4'd15);
        chk("flush_wrap_count", rob_count, 2);
        dsp();
        chk("post_flush_dispatch", rob_count, 3);
        step(0, 1, 4'd1, 0, 4'd0);
        chk("stale_cdb_ignored", {commit_valid, rob_count}, {1'b0, 5'd3});
        drain();

        // Full ROB, head done: commit and dispatch together.
        do_reset();
        repeat (16) dsp();
        step(0, 1, 4'd0, 0, 4'd0);
        dsp();
        chk("full_commit_drops_dispatch", rob_count, 15);
        dsp();
        chk("refill_after_commit", rob_count, 16);
        drain();

        // Flush at head while head commits.
        do_reset();
        repeat (3) dsp();
        step(0, 1, 4'd0, 0, 4'd0);
        step(0, 0, 4'd0, 1, 4'd0);
        chk("flush_head_commit_empty", {rob_empty, rob_count}, {1'b1, 5'd0});
        dsp();
        chk("next_tag_after_flush", {rob_count, dispatch_tag}, {5'd1, 4'd1});
        drain();

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit         dv, cv, bm;
            logic [3:0] ct, rt;
            dv = ($urandom % 10) < 6;
            cv = ($urandom % 10) < 6;
            bm = ($urandom % 25) == 0;
            ct = 4'($urandom);
            rt = 4'($urandom);
            if (m_q.size() > 0 && ($urandom % 4) != 0)
                ct = m_q[$urandom_range(0, m_q.size() - 1)].tag;
            if (m_q.size() > 0 && ($urandom % 4) != 0)
                rt = m_q[$urandom_range(0, m_q.size() - 1)].tag;
            step(dv, cv, ct, bm, rt);
        end
        drain();
        idle();

        @(negedge clk); #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer fed by the ROB tag allocator at dispatch. It holds per-instruction rename state, marks entries complete from the CDB, and retires at most one instruction per cycle in program order.
- Commit outputs go to the free list (old_preg release) and the retirement RAT.
- On a branch mispredict it discards every entry younger than the mispredicting branch. This matches the allocator restoring its tag counter to recovery_tag+1.

Parameters:
- ROB_WIDTH, 4, log2 of entry count (16 entries); tag width
- AREG_WIDTH, 5, architectural register index width
- PREG_WIDTH, 7, physical register index width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- dispatch_valid  input  1  allocate entry this cycle
- dispatch_tag  input  ROB_WIDTH  tag from allocator; must equal internal tail
- dispatch_has_dest  input  1  instruction writes a register
- dispatch_areg  input  AREG_WIDTH  destination architectural reg
- dispatch_preg  input  PREG_WIDTH  newly mapped physical reg
- dispatch_old_preg  input  PREG_WIDTH  previous mapping, freed at commit
- rob_full  output  1  count == 2**ROB_WIDTH
- rob_empty  output  1  count == 0
- rob_count  output  ROB_WIDTH+1  occupied entries
- cdb_valid  input  1  completion broadcast
- cdb_tag  input  ROB_WIDTH  completing tag
- branch_mispredict  input  1  flush younger than recovery_tag
- recovery_tag  input  ROB_WIDTH  tag of mispredicting branch
- commit_valid  output  1  head retires at this clock edge
- commit_tag  output  ROB_WIDTH  retiring tag (= head)
- commit_has_dest  output  1  retiring entry writes a reg
- commit_areg  output  AREG_WIDTH  retiring arch reg
- commit_preg  output  PREG_WIDTH  retiring phys reg
- commit_old_preg  output  PREG_WIDTH  phys reg to return to free list

Behaviour:
- State:
  - head[ROB_WIDTH-1:0] and count[ROB_WIDTH:0].
  - Per entry: valid, done, has_dest, areg, preg, old_preg.
  - tail = head + count[ROB_WIDTH-1:0], computed modulo 2**ROB_WIDTH.
- Reset: head=0, count=0, all valid and done bits cleared. Outputs then read rob_empty=1, rob_full=0, rob_count=0, commit_valid=0, all commit_* fields 0.
- Dispatch:
  - Accepted at the clock edge when dispatch_valid && !rob_full && !branch_mispredict.
  - Writes the entry at dispatch_tag with valid=1, done=0, and the payload; count increments.
  - Dispatch while full, or in a mispredict cycle, is dropped with no state change.
  - dispatch_tag != tail is a protocol violation; a simulation assertion fires.
- Completion:
  - cdb_valid sets done[cdb_tag] at the clock edge, only if that entry is valid; otherwise it is ignored.
  - CDB and dispatch to the same tag in one cycle: dispatch wins, done=0.
- Commit:
  - commit_valid = valid[head] && done[head]. It is combinational from registered state, with no handshake, since retirement is always accepted.
  - commit_* fields show the head entry while commit_valid=1 and read 0 otherwise.
  - On commit: valid[head] cleared, head increments with wrap at 2**ROB_WIDTH, count decrements.
  - Minimum latency: CDB at cycle N allows commit_valid at cycle N+1.
- Mispredict:
  - Applies only if valid[recovery_tag]; otherwise the whole flush is ignored.
  - Keeps entries head..recovery_tag inclusive. New count = ((recovery_tag - head) mod 2**ROB_WIDTH) + 1, minus 1 if a commit also occurs that cycle.
  - All entries younger than recovery_tag: valid and done cleared.
  - A CDB write to a flushed tag in the same cycle is discarded.
  - Same-cycle commit of the head is still performed (head is never younger than the branch).
  - If recovery_tag == head and the head commits that cycle, count becomes 0.
- Simultaneous dispatch and commit: count is unchanged. A full ROB still refuses dispatch that cycle, because rob_full is computed from registered count.
- Wrap-around: head, tail and tags wrap modulo 16. count=16 means full; count=0 means empty.
- Reset mid-operation overrides dispatch, CDB, commit and flush in the same cycle.

Test Plan:
- Reset, then dispatch tags 0..15 with no CDB -> rob_full=1, rob_count=16; 17th dispatch dropped; commit_valid stays 0.
- Dispatch tags 0,1,2; CDB tag 2 then tag 0 -> tag 0 commits one cycle after its CDB; tag 2 does not commit before tag 1 completes; CDB tag 1 -> tags 1 and 2 commit on consecutive cycles.
- Dispatch tag 0 with has_dest=1, areg=5, preg=40, old_preg=5; CDB tag 0 -> next cycle commit_valid=1, commit_areg=5, commit_preg=40, commit_old_preg=5, commit_tag=0.
- head=14, dispatch tags 14,15,0,1,2; mispredict recovery_tag=15 -> rob_count=2; later dispatch tag 0 accepted; late CDB for old tag 1 ignored.
- Full ROB with head done: commit and dispatch asserted together -> commit occurs, dispatch dropped, rob_count=15; next-cycle dispatch accepted.
- Mispredict with recovery_tag==head while head commits -> rob_empty=1, rob_count=0, next dispatch expected at tag head+1.
